// File: rtl/bcd2421_seq_if.sv
// Handshake/data bundle between a packed-BCD source and the 2421 sequencer.
interface bcd2421_seq_if #(parameter int DIGITS = 4);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   w_out;
  logic                  err;

  modport master (output start, bcd_in, input busy, done, w_out, err);
  modport slave  (input start, bcd_in, output busy, done, w_out, err);
endinterface

// File: rtl/bcd2421_seq.sv
// Converts a packed BCD word to 2421 code one digit per clock, LSD first,
// through a single shared digit converter.
module bcd2421_seq #(
    parameter int DIGITS = 4
) (
    input logic             clk,
    input logic             rst_n,
    bcd2421_seq_if.slave    bus
);
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int W  = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    work;
    logic [W-1:0]    res;
    logic            werr;
    logic            busy_r, done_r, err_r;
    logic [W-1:0]    w_out_r;

    logic [3:0]      cur_d, cur_w;
    logic            cur_bad;
    logic [W-1:0]    res_next;

    // Shared converter: digit under the counter, invalid codes map to 0000.
    always_comb begin
        cur_d   = work[4*int'(cnt) +: 4];
        cur_bad = 1'b0;
        case (cur_d)
            4'd0: cur_w = 4'b0000;
            4'd1: cur_w = 4'b0001;
            4'd2: cur_w = 4'b0010;
            4'd3: cur_w = 4'b0011;
            4'd4: cur_w = 4'b0100;
            4'd5: cur_w = 4'b1011;
            4'd6: cur_w = 4'b1100;
            4'd7: cur_w = 4'b1101;
            4'd8: cur_w = 4'b1110;
            4'd9: cur_w = 4'b1111;
            default: begin
                cur_w   = 4'b0000;
                cur_bad = 1'b1;
            end
        endcase
    end

    // Result including the slot being converted this cycle, so the final
    // digit can go straight into the output register on the last CONV edge.
    always_comb begin
        res_next = res;
        res_next[4*int'(cnt) +: 4] = cur_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            work    <= '0;
            res     <= '0;
            werr    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            w_out_r <= '0;
            err_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state  <= CONV;
                        work   <= bus.bcd_in;
                        cnt    <= '0;
                        werr   <= 1'b0;
                        busy_r <= 1'b1;
                    end
                end
                CONV: begin
                    res  <= res_next;
                    werr <= werr | cur_bad;
                    if (cnt == CW'(DIGITS - 1)) begin
                        state   <= DONE;
                        done_r  <= 1'b1;
                        w_out_r <= res_next;
                        err_r   <= werr | cur_bad;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.w_out = w_out_r;
    assign bus.err   = err_r;
endmodule
